// File: rtl/fir_pkg.sv
// Shared FIR definitions: stage widths, filtered-sample type, rounding/saturation helper.
// Latency: none (package only).
// Backpressure: n/a.
package fir_pkg;

    localparam int FIR_IN_W  = 8;
    localparam int FIR_OUT_W = 16;

    typedef logic signed [FIR_OUT_W-1:0] fir_sample_t;

    // Round-half-up arithmetic right shift by 'shift', then clamp to a signed
    // 'out_w'-bit range. Operands live in 32 bits so callers with different
    // widths can share it; the caller truncates the result to out_w bits.
    // Requires shift >= 1 and the input plus the rounding half to fit in 31 bits.
    function automatic logic signed [31:0] sat_round(
        input logic signed [31:0] x,
        input int                 shift,
        input int                 out_w
    );
        logic signed [31:0] r;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        r  = (x + (32'sd1 <<< (shift - 1))) >>> shift;
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (out_w - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_out_decimator_if.sv
// Output stream bundle of the decimator: valid/ready data plus occupancy and overflow status.
// Latency: none (wiring only).
// Backpressure: slave drives m_ready_i; master holds m_valid_o/m_data_o until accepted.
// Parameters must match the fir_out_decimator instance they connect to.
interface fir_out_decimator_if #(
    parameter int OUT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 8
);
    logic                                 m_valid_o;
    logic                                 m_ready_i;
    logic signed [OUT_WIDTH-1:0]          m_data_o;
    logic [$clog2(FIFO_DEPTH+1)-1:0]      count_o;
    logic                                 overflow_o;

    modport master (output m_valid_o, m_data_o, count_o, overflow_o, input m_ready_i);
    modport slave  (input m_valid_o, m_data_o, count_o, overflow_o, output m_ready_i);
endinterface

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO with registered storage; head is presented combinationally from storage.
// Latency: a push is visible at the head the cycle after it is written (no bypass).
// Backpressure: push while full is refused unless a pop happens in the same cycle.
// Ports: clk_i, rst_n_i, push_i/push_dat_i, pop_i/pop_dat_o, full_o, empty_o, count_o.
module fir_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               push_dat_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               pop_dat_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // When full, the slot freed by a concurrent pop is reused in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fir_out_decimator.sv
// Keeps every DECIM-th enabled filter sample, rescales (round-half-up shift + saturate), buffers in a FIFO.
// Latency: kept sample appears on m_valid_o/m_data_o one cycle after its en_i cycle when the FIFO is empty.
// Backpressure: m_ready_i low holds the head; a kept sample arriving while full without a pop is dropped and sets sticky overflow_o.
// Ports: clk_i, rst_n_i, en_i, filtered_i, m_if (master: m_valid_o, m_ready_i, m_data_o, count_o, overflow_o).
// Build option FIR_DECIM_ACCUM_EN: boxcar-sum DECIM samples (DECIM power of two) instead of picking one.
module fir_out_decimator
    import fir_pkg::*;
#(
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 8,
    parameter int SHIFT      = 7,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        en_i,
    input  logic signed [IN_WIDTH-1:0]  filtered_i,
    fir_out_decimator_if.master         m_if
);
    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        overflow_q, overflow_d;
    logic                        keep;
    logic                        fifo_full, fifo_empty;
    logic signed [OUT_WIDTH-1:0] scaled;

    assign keep = en_i && (cnt_q == CNT_W'(DECIM - 1));

`ifdef FIR_DECIM_ACCUM_EN
    localparam int LOG_D = $clog2(DECIM);
    localparam int ACC_W = IN_WIDTH + LOG_D;

    logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;

    // The kept sample is included in the sum it closes; the accumulator then restarts at zero.
    assign acc_sum = acc_q + ACC_W'(filtered_i);
    assign scaled  = OUT_WIDTH'(sat_round(32'(acc_sum), SHIFT + LOG_D, OUT_WIDTH));

    always_comb begin
        acc_d = acc_q;
        if (keep) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_sum;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    assign scaled = OUT_WIDTH'(sat_round(32'(filtered_i), SHIFT, OUT_WIDTH));
`endif

    always_comb begin
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        if (keep) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Full implies non-empty, so ready alone decides whether a pop frees a slot.
        if (keep && fifo_full && !m_if.m_ready_i) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    fir_sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .push_i     (keep),
        .push_dat_i (scaled),
        .pop_i      (m_if.m_ready_i),
        .pop_dat_o  (m_if.m_data_o),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (m_if.count_o)
    );

    assign m_if.m_valid_o  = !fifo_empty;
    assign m_if.overflow_o = overflow_q;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Randomized and directed bench for fir_out_decimator against a queue-based reference model.
// Latency: n/a.
// Backpressure: m_ready_i is driven by the bench (held low, high, and random).
module tb_fir_out_decimator;
    import fir_pkg::*;

    localparam int IN_WIDTH   = 16;
    localparam int OUT_WIDTH  = 8;
    localparam int SHIFT      = 7;
    localparam int DECIM      = 4;
    localparam int FIFO_DEPTH = 8;
`ifdef FIR_DECIM_ACCUM_EN
    localparam int EFF_SHIFT  = SHIFT + 2;
`else
    localparam int EFF_SHIFT  = SHIFT;
`endif

    logic        clk_i      = 1'b0;
    logic        rst_n_i    = 1'b0;
    logic        en_i       = 1'b0;
    fir_sample_t filtered_i = '0;

    fir_out_decimator_if #(.OUT_WIDTH(OUT_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) m_if ();

    fir_out_decimator #(
        .IN_WIDTH   (IN_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .SHIFT      (SHIFT),
        .DECIM      (DECIM),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .en_i       (en_i),
        .filtered_i (filtered_i),
        .m_if       (m_if)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: expected FIFO contents, samples of the current group, sample index.
    int exp_q[$];
    int win_q[$];
    int en_cnt  = 0;
    bit exp_ovf = 1'b0;

    task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Round-half-up division by 2^s using floor division, then clamp to the output range.
    function automatic int ref_scale(input int v);
        int d;
        int n;
        int q;
        int lim;
        d   = 1 << EFF_SHIFT;
        n   = v + d / 2;
        q   = n / d;
        if ((n % d) != 0 && n < 0) q = q - 1;
        lim = 1 << (OUT_WIDTH - 1);
        if (q > lim - 1) q = lim - 1;
        if (q < -lim) q = -lim;
        return q;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        win_q.delete();
        en_cnt  = 0;
        exp_ovf = 1'b0;
    endtask

    task automatic model_edge();
        int sz;
        bit pop;
        int val;
        int dummy;
        if (!rst_n_i) begin
            model_reset();
            return;
        end
        sz  = exp_q.size();
        pop = (sz > 0) && m_if.m_ready_i;
        if (pop) dummy = exp_q.pop_front();
        if (en_i) begin
            win_q.push_back(int'(filtered_i));
            if (win_q.size() > DECIM) dummy = win_q.pop_front();
            if ((en_cnt % DECIM) == DECIM - 1) begin
`ifdef FIR_DECIM_ACCUM_EN
                val = 0;
                foreach (win_q[i]) val += win_q[i];
`else
                val = int'(filtered_i);
`endif
                val = ref_scale(val);
                if (sz < FIFO_DEPTH || pop) exp_q.push_back(val);
                else exp_ovf = 1'b1;
            end
            en_cnt++;
        end
    endtask

    task automatic check_outputs();
        chk("valid", 32'(m_if.m_valid_o), 32'(exp_q.size() > 0));
        chk("count", 32'(m_if.count_o), exp_q.size());
        chk("overflow", 32'(m_if.overflow_o), 32'(exp_ovf));
        if (exp_q.size() > 0) chk("data", m_if.m_data_o, exp_q[0]);
    endtask

    // Drive one cycle of inputs, advance the model on the edge, check 1 time unit later.
    task automatic step(input bit en, input int d, input bit rdy);
        en_i           = en;
        filtered_i     = fir_sample_t'(d);
        m_if.m_ready_i = rdy;
        @(posedge clk_i);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        #2;
        rst_n_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
    endtask

    initial begin
        int lit_a;
        int lit_b;
        int r_pct;
        int d;
        int vals[4];
        int exps[4];
        m_if.m_ready_i = 1'b0;

        // Reset held with en_i toggling: all outputs stay zero.
        for (int i = 0; i < 4; i++) begin
            step(i[0], 1280, 1'b1);
            chk("rst_data", m_if.m_data_o, 0);
        end
        #2;
        rst_n_i = 1'b1;

        // Asynchronous reset with three entries queued clears before the next edge.
        for (int i = 0; i < 12; i++) step(1'b1, 1280 + i, 1'b0);
        chk("pre_rst_count", 32'(m_if.count_o), 3);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("async_count", 32'(m_if.count_o), 0);
        chk("async_valid", 32'(m_if.m_valid_o), 0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;

        // Constant 1280 -> 10, valid pulses one cycle after every 4th sample.
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1280, 1'b1);
            chk("pulse", 32'(m_if.m_valid_o), 32'((i % 4) == 0));
            if ((i % 4) == 0) chk("const_val", m_if.m_data_o, 10);
        end

        // Rounding and saturation corners.
        vals = '{192, -192, 32767, -32768};
        exps = '{2, -1, 127, -128};
        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int i = 0; i < 4; i++) step(1'b1, vals[v], 1'b1);
            chk("round_sat", m_if.m_data_o, exps[v]);
        end

        // Enable on alternate cycles: counter frozen in the gaps.
`ifdef FIR_DECIM_ACCUM_EN
        lit_a = 3;
        lit_b = 7;
`else
        lit_a = 4;
        lit_b = 8;
`endif
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 128 * k, 1'b1);
            if (k == 4) chk("gap_first", m_if.m_data_o, lit_a);
            if (k == 8) chk("gap_second", m_if.m_data_o, lit_b);
            step(1'b0, int'($urandom_range(0, 4000)) - 2000, 1'b1);
        end

        // Backpressure: nine kept samples into eight slots, then drain.
        do_reset();
        for (int i = 0; i < 36; i++) step(1'b1, int'($urandom_range(0, 20000)) - 10000, 1'b0);
        chk("bp_count", 32'(m_if.count_o), 8);
        chk("bp_overflow", 32'(m_if.overflow_o), 1);
        for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1);
        chk("bp_sticky", 32'(m_if.overflow_o), 1);
        chk("bp_drained", 32'(m_if.count_o), 0);

        // Full FIFO with a pop in the kept cycle: push accepted, no overflow.
        do_reset();
        for (int i = 0; i < 35; i++) step(1'b1, int'($urandom_range(0, 20000)) - 10000, 1'b0);
        step(1'b1, 5000, 1'b1);
        chk("full_pop_count", 32'(m_if.count_o), 8);
        chk("full_pop_ovf", 32'(m_if.overflow_o), 0);

`ifdef FIR_DECIM_ACCUM_EN
        do_reset();
        step(1'b1, 100, 1'b1);
        step(1'b1, 200, 1'b1);
        step(1'b1, 300, 1'b1);
        step(1'b1, 400, 1'b1);
        chk("accum_sum", m_if.m_data_o, 2);
`endif

        // Random traffic with varying downstream readiness.
        do_reset();
        for (int blk = 0; blk < 10; blk++) begin
            r_pct = int'($urandom_range(0, 100));
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 3) == 0) d = int'($urandom_range(0, 65535)) - 32768;
                else d = int'($urandom_range(0, 4000)) - 2000;
                step($urandom_range(0, 3) != 0, d, int'($urandom_range(0, 99)) < r_pct);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
